// File: rtl/johnson_seq_ctrl.sv
// Run controller owning a WIDTH-bit Johnson counter: load, N-step runs in either direction, hold, done pulse.
// Optional build macro JOHNSON_FIX_EN: a run step taken from an illegal pattern clears q instead of shifting.
module johnson_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             dir,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;

    logic [WIDTH-1:0] fwd, rev, shifted;
    logic [WIDTH-2:0] edges;

    // A Johnson pattern has at most one boundary between adjacent differing bits.
    assign edges   = cnt_q[WIDTH-2:0] ^ cnt_q[WIDTH-1:1];
    assign illegal = (edges & (edges - (WIDTH-1)'(1))) != '0;

    assign fwd     = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
    assign rev     = {~cnt_q[0], cnt_q[WIDTH-1:1]};
    assign shifted = dir_q ? rev : fwd;

    assign q    = cnt_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    cnt_d = load_val;
                end else if (start) begin
                    if (steps != '0) begin
                        rem_d   = steps;
                        dir_d   = dir;
                        state_d = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (!hold) begin
`ifdef JOHNSON_FIX_EN
                    cnt_d = illegal ? '0 : shifted;
`else
                    cnt_d = shifted;
`endif
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl (WIDTH=4): directed scenarios plus randomized traffic vs a model.
// Honours JOHNSON_FIX_EN the same way the design does.
module tb_johnson_seq_ctrl;

    localparam int W = 4;
    localparam int M = 2 * W;

    logic       clk = 1'b0;
    logic       reset, start, dir, hold, load;
    logic [7:0] steps;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       busy, done, illegal;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    johnson_seq_ctrl #(.WIDTH(W), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .steps    (steps),
        .dir      (dir),
        .hold     (hold),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // k-th state of the forward Johnson sequence starting at all zeros
    function automatic logic [3:0] jstate(int k);
        if (k < W) return 4'((1 << k) - 1);
        return 4'(~((1 << (k - W)) - 1));
    endfunction

    function automatic int jindex(logic [3:0] v);
        for (int k = 0; k < M; k++) if (jstate(k) == v) return k;
        return -1;
    endfunction

    function automatic logic [3:0] step(logic [3:0] v, logic d);
        int k;
        k = jindex(v);
        if (k >= 0) return jstate(d ? (k + M - 1) % M : (k + 1) % M);
        return d ? {~v[0], v[3:1]} : {v[2:0], ~v[3]};
    endfunction

    // Behavioural model: phase 0 idle, 1 running, 2 done
    logic [3:0] m_q;
    int         m_phase, m_rem;
    logic       m_dir;

    always @(posedge clk) begin
        if (reset) begin
            m_q <= '0; m_phase <= 0; m_rem <= 0; m_dir <= 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (load) m_q <= load_val;
                    else if (start && steps != 0) begin
                        m_rem <= int'(steps); m_dir <= dir; m_phase <= 1;
                    end else if (start) m_phase <= 2;
                end
                1: if (!hold) begin
`ifdef JOHNSON_FIX_EN
                    m_q <= (jindex(m_q) < 0) ? 4'd0 : step(m_q, m_dir);
`else
                    m_q <= step(m_q, m_dir);
`endif
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) m_phase <= 2;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_q", 32'(q), 32'(m_q));
            chk("model_busy", 32'(busy), 32'(m_phase == 1));
            chk("model_done", 32'(done), 32'(m_phase == 2));
            chk("model_illegal", 32'(illegal), 32'(jindex(m_q) < 0));
        end
    end

    task automatic do_load(logic [3:0] v);
        load = 1'b1; load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_steps(int n, logic d);
        int i;
        steps = 8'(n); dir = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (i = 0; i < 400; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("run_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 0; dir = 0; hold = 0; load = 0; steps = '0; load_val = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset = 1'b0;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);

        // steps=3 forward from reset
        start = 1'b1; steps = 8'd3; dir = 1'b0;
        @(negedge clk); start = 1'b0;
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_q", 32'(q), 32'h0);
        @(negedge clk); chk("t2_q", 32'(q), 32'h1);
        @(negedge clk); chk("t3_q", 32'(q), 32'h3); chk("t3_done", 32'(done), 32'h0);
        @(negedge clk); chk("t4_q", 32'(q), 32'h7); chk("t4_done", 32'(done), 32'h1);
        chk("t4_busy", 32'(busy), 32'h0);
        @(negedge clk); chk("t5_done", 32'(done), 32'h0);

        // wrap-around and reverse
        do_load(4'h0); run_steps(8, 1'b0); chk("wrap8_q", 32'(q), 32'h0);
        @(negedge clk);
        do_load(4'h0); run_steps(9, 1'b0); chk("wrap9_q", 32'(q), 32'h1);
        @(negedge clk);
        do_load(4'h0); run_steps(1, 1'b1); chk("rev1_q", 32'(q), 32'h8);
        @(negedge clk);

        // hold for 2 cycles mid-run
        do_load(4'h0);
        steps = 8'd4; dir = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); chk("hold_n2_q", 32'(q), 32'h1); hold = 1'b1;
        @(negedge clk); chk("hold_n3_q", 32'(q), 32'h1); chk("hold_n3_busy", 32'(busy), 32'h1);
        @(negedge clk); chk("hold_n4_q", 32'(q), 32'h1); hold = 1'b0;
        @(negedge clk); chk("hold_n5_q", 32'(q), 32'h3);
        @(negedge clk); chk("hold_n6_q", 32'(q), 32'h7); chk("hold_n6_done", 32'(done), 32'h0);
        @(negedge clk); chk("hold_n7_q", 32'(q), 32'hF); chk("hold_n7_done", 32'(done), 32'h1);
        @(negedge clk);

        // illegal pattern
        do_load(4'b0101);
        chk("ill_load", 32'(illegal), 32'h1);
        run_steps(1, 1'b0);
`ifdef JOHNSON_FIX_EN
        chk("ill_step_q", 32'(q), 32'h0); chk("ill_step_ill", 32'(illegal), 32'h0);
`else
        chk("ill_step_q", 32'(q), 32'hB); chk("ill_step_ill", 32'(illegal), 32'h1);
`endif
        @(negedge clk);

        // start while busy is ignored
        do_load(4'h0);
        steps = 8'd2; dir = 1'b0; start = 1'b1;
        @(negedge clk); steps = 8'd5;
        @(negedge clk); start = 1'b0;
        chk("busy_start_q", 32'(q), 32'h1);
        @(negedge clk); chk("busy_start_done", 32'(done), 32'h1); chk("busy_start_fq", 32'(q), 32'h3);
        @(negedge clk); chk("busy_start_idle", 32'(busy), 32'h0);

        // load and start together: load wins
        load = 1'b1; load_val = 4'h6; start = 1'b1; steps = 8'd3;
        @(negedge clk); load = 1'b0; start = 1'b0;
        chk("ld_st_q", 32'(q), 32'h6); chk("ld_st_busy", 32'(busy), 32'h0);
        @(negedge clk); chk("ld_st_busy2", 32'(busy), 32'h0); chk("ld_st_done", 32'(done), 32'h0);

        // steps = 0
        steps = 8'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("z_done", 32'(done), 32'h1); chk("z_busy", 32'(busy), 32'h0); chk("z_q", 32'(q), 32'h6);
        @(negedge clk); chk("z_done2", 32'(done), 32'h0);

        // reset mid-run
        do_load(4'h0);
        steps = 8'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mr_q", 32'(q), 32'h0); chk("mr_busy", 32'(busy), 32'h0); chk("mr_done", 32'(done), 32'h0);
        @(negedge clk); chk("mr_done2", 32'(done), 32'h0);
        run_steps(2, 1'b0); chk("mr_rerun_q", 32'(q), 32'h3);

        // randomized traffic, checked by the model every cycle
        repeat (3000) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 3) == 0);
            steps    = 8'($urandom_range(0, 20));
            dir      = 1'($urandom);
            hold     = ($urandom_range(0, 3) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; load = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
